// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the raw pins, deserialises 11-bit frames,
// checks start/odd-parity/stop bits and buffers good bytes in a FWFT FIFO.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic                   prev_clk_reg;
    logic                   sync_clk;
    logic                   sync_dat;
    logic                   fall;

    state_t                 state_reg;
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt_reg;
    logic                   parity_reg;
    logic [TW-1:0]          idle_cnt_reg;
    logic                   frame_err_reg;
    logic                   overflow_reg;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_reg;
    logic [AW-1:0]          rd_ptr_reg;
    logic [CW-1:0]          count_reg;

    logic                   frame_good;
    logic                   push;
    logic                   pop;
    logic                   push_ok;

    // Synchronisers idle high so reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_reg <= '1;
            dat_sync_reg <= '1;
            prev_clk_reg <= 1'b1;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ps2_dat};
            prev_clk_reg <= sync_clk;
        end
    end

    assign sync_clk = clk_sync_reg[SYNC_STAGES-1];
    assign sync_dat = dat_sync_reg[SYNC_STAGES-1];
    assign fall     = prev_clk_reg & ~sync_clk;

    // Odd parity over data plus parity bit, stop bit must be high.
    assign frame_good = sync_dat & ((^shift_reg) ^ parity_reg);
    assign push       = fall && (state_reg == STOP) && frame_good;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            parity_reg    <= 1'b0;
            idle_cnt_reg  <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            if (fall) begin
                idle_cnt_reg <= '0;
            end else if (idle_cnt_reg != TIMEOUT_VAL) begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end

            if (fall) begin
                case (state_reg)
                    IDLE: begin
                        if (!sync_dat) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg   <= {sync_dat, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_reg <= sync_dat;
                        state_reg  <= STOP;
                    end
                    STOP: begin
                        frame_err_reg <= ~frame_good;
                        state_reg     <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end else if (state_reg != IDLE && idle_cnt_reg == TIMEOUT_VAL) begin
                state_reg <= IDLE;
            end
        end
    end

    assign pop     = out_valid && out_ready;
    // A full FIFO still takes the byte if the head leaves in the same cycle.
    assign push_ok = push && ((count_reg != FULL_COUNT) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out_valid = (count_reg != '0);
    assign data_out  = out_valid ? mem[rd_ptr_reg] : 8'h00;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames with hand-computed
// expected bytes, error pulses, overflow and reset behaviour.
module tb_ps2_rx_fifo;
    localparam int TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int valid_cnt = 0;
    int err_base;
    int valid_base;

    ps2_rx_fifo #(
        .FIFO_DEPTH(8),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .data_out(data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (out_valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_fall(input logic b);
        @(negedge clk);
        ps2_dat = b;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic ps2_rise();
        repeat (16) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_fall(b);
        ps2_rise();
    endtask

    task automatic send_head(input logic [7:0] d, input logic par_inv);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ par_inv);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_inv, input logic stop);
        send_head(d, par_inv);
        ps2_bit(stop);
        repeat (5) @(negedge clk);
    endtask

    task automatic drain_check(input string tag, input logic [7:0] first, input int n);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, out_valid, 1'b1);
            check({tag, "_data"}, data_out, first + 8'(i));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check({tag, "_empty"}, out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", data_out, 8'h00);
        check("rst_err", frame_err, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0x1C good frame, latency of the push after the stop falling edge
        out_ready = 1'b1;
        send_head(8'h1C, 1'b0);
        ps2_fall(1'b1);
        @(posedge clk); #1; check("lat_e1", out_valid, 1'b0);
        @(posedge clk); #1; check("lat_e2", out_valid, 1'b0);
        @(posedge clk); #1; check("lat_e3_valid", out_valid, 1'b1);
        check("lat_e3_data", data_out, 8'h1C);
        @(posedge clk); #1; check("lat_e4_popped", out_valid, 1'b0);
        ps2_rise();
        repeat (5) @(negedge clk);
        check("good_no_err", err_cnt, 0);
        check("good_one_valid", valid_cnt, 1);

        // parity error then stop error
        err_base = err_cnt;
        valid_base = valid_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_err_pulse", err_cnt, err_base + 1);
        send_frame(8'hF0, 1'b0, 1'b0);
        check("stop_err_pulse", err_cnt, err_base + 2);
        check("err_no_valid", valid_cnt, valid_base);
        check("err_no_ovf", overflow, 1'b0);
        ps2_dat = 1'b1;

        // overflow: nine frames into an eight-entry FIFO
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 1'b0, 1'b1);
            if (k == 8) check("ovf_after8", overflow, 1'b0);
        end
        check("ovf_after9", overflow, 1'b1);
        drain_check("ovf_drain", 8'h01, 8);
        check("ovf_sticky", overflow, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // full FIFO with a pop in the very cycle of the ninth push
        for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0, 1'b1);
        send_head(8'h09, 1'b0);
        ps2_fall(1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); out_ready = 1'b0;
        ps2_rise();
        repeat (5) @(negedge clk);
        check("simul_no_ovf", overflow, 1'b0);
        drain_check("simul_drain", 8'h02, 8);

        // partial frame abandoned by the timeout
        err_base = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (TIMEOUT + 10) @(negedge clk);
        check("to_silent", err_cnt, err_base);
        check("to_no_valid", out_valid, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("to_no_err", err_cnt, err_base);
        drain_check("to_f0", 8'hF0, 1);

        // reset in the middle of a frame with two bytes buffered
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        check("mid_buffered", out_valid, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_data", data_out, 8'h00);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        err_base = err_cnt;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("after_rst_no_err", err_cnt, err_base);
        drain_check("after_rst_5a", 8'h5A, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
